// File: rtl/pwl_act_pkg.sv
// Shared Q5.11 constants, the 9-slice tanh table and its segment decoder
// for the piecewise-linear activation unit.
package pwl_act_pkg;

  localparam int W    = 16;
  localparam int FRAC = 11;
  localparam int ONE  = 2048;
  localparam int HALF = ONE / 2;

  localparam logic signed [W-1:0] BP_0 = -16'sd6144;
  localparam logic signed [W-1:0] BP_1 = -16'sd4779;
  localparam logic signed [W-1:0] BP_2 = -16'sd3413;
  localparam logic signed [W-1:0] BP_3 = -16'sd2048;
  localparam logic signed [W-1:0] BP_4 = -16'sd683;
  localparam logic signed [W-1:0] BP_5 = 16'sd683;
  localparam logic signed [W-1:0] BP_6 = 16'sd2048;
  localparam logic signed [W-1:0] BP_7 = 16'sd3413;
  localparam logic signed [W-1:0] BP_8 = 16'sd4779;
  localparam logic signed [W-1:0] BP_9 = 16'sd6144;

  localparam logic signed [W-1:0] M_0 = 16'sd42;
  localparam logic signed [W-1:0] M_1 = 16'sd154;
  localparam logic signed [W-1:0] M_2 = 16'sd521;
  localparam logic signed [W-1:0] M_3 = 16'sd1352;
  localparam logic signed [W-1:0] M_4 = 16'sd1975;
  localparam logic signed [W-1:0] M_5 = 16'sd1352;
  localparam logic signed [W-1:0] M_6 = 16'sd521;
  localparam logic signed [W-1:0] M_7 = 16'sd154;
  localparam logic signed [W-1:0] M_8 = 16'sd42;

  localparam logic signed [W-1:0] C_0 = -16'sd1912;
  localparam logic signed [W-1:0] C_1 = -16'sd1650;
  localparam logic signed [W-1:0] C_2 = -16'sd1039;
  localparam logic signed [W-1:0] C_3 = -16'sd208;
  localparam logic signed [W-1:0] C_4 = 16'sd0;
  localparam logic signed [W-1:0] C_5 = 16'sd208;
  localparam logic signed [W-1:0] C_6 = 16'sd1039;
  localparam logic signed [W-1:0] C_7 = 16'sd1650;
  localparam logic signed [W-1:0] C_8 = 16'sd1912;

  localparam logic signed [W-1:0] SAT_LOW  = -16'sd2038;
  localparam logic signed [W-1:0] SAT_HIGH = 16'sd2038;

  typedef struct packed {
    logic signed [W-1:0] m;
    logic signed [W-1:0] c;
    logic                sat_lo;
    logic                sat_hi;
  } seg_t;

  // Each segment owns its lower breakpoint: BP_k <= xs < BP_k+1.
  function automatic seg_t seg_decode(input logic signed [W-1:0] xs);
    seg_t s;
    s = '0;
    if (xs < BP_0)       s.sat_lo = 1'b1;
    else if (xs >= BP_9) s.sat_hi = 1'b1;
    else if (xs < BP_1)  begin s.m = M_0; s.c = C_0; end
    else if (xs < BP_2)  begin s.m = M_1; s.c = C_1; end
    else if (xs < BP_3)  begin s.m = M_2; s.c = C_2; end
    else if (xs < BP_4)  begin s.m = M_3; s.c = C_3; end
    else if (xs < BP_5)  begin s.m = M_4; s.c = C_4; end
    else if (xs < BP_6)  begin s.m = M_5; s.c = C_5; end
    else if (xs < BP_7)  begin s.m = M_6; s.c = C_6; end
    else if (xs < BP_8)  begin s.m = M_7; s.c = C_7; end
    else                 begin s.m = M_8; s.c = C_8; end
    return s;
  endfunction

endpackage

// File: rtl/pwl_lane.sv
// One lane of the activation datapath: decode, multiply-add, saturate and
// sigmoid remap, each behind a register gated by the shared advance enable.
module pwl_lane
  import pwl_act_pkg::*;
#(
  parameter bit ROUND = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         adv_i,
  input  logic         load_i,
  input  logic         mode_i,
  input  logic         mode_s3_i,
  input  logic [W-1:0] x_i,
  output logic [W-1:0] y_o,
  output logic         sat_o
);

  logic signed [W-1:0] x_s, xs_d, xs_q;
  seg_t                seg_d, seg_q;
  logic signed [31:0]  prod, prod_r, prod_sh, sum_w;
  logic signed [W-1:0] t_d, t_q, t_sel, y_d, y_q;
  logic                sat_lo_q, sat_hi_q, sat_q;

  assign x_s   = x_i;
  assign xs_d  = mode_i ? (x_s >>> 1) : x_s;
  assign seg_d = seg_decode(xs_d);

  assign prod    = 32'(seg_q.m) * 32'(xs_q);
  assign prod_r  = prod + (ROUND ? 32'(HALF) : 32'sd0);
  assign prod_sh = prod_r >>> FRAC;
  assign sum_w   = prod_sh + 32'(seg_q.c);

  // Clamp to the 16-bit signed range; only reachable on table edits.
  always_comb begin
    t_d = sum_w[W-1:0];
    if (sum_w > 32'sd32767)       t_d = 16'sh7fff;
    else if (sum_w < -32'sd32768) t_d = 16'sh8000;
  end

  always_comb begin
    t_sel = t_q;
    if (sat_hi_q)      t_sel = SAT_HIGH;
    else if (sat_lo_q) t_sel = SAT_LOW;
    y_d = mode_s3_i ? ((t_sel >>> 1) + W'(HALF)) : t_sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xs_q     <= '0;
      seg_q    <= '0;
      t_q      <= '0;
      sat_lo_q <= 1'b0;
      sat_hi_q <= 1'b0;
      y_q      <= '0;
      sat_q    <= 1'b0;
    end else begin
      if (load_i) begin
        xs_q  <= xs_d;
        seg_q <= seg_d;
      end
      if (adv_i) begin
        t_q      <= t_d;
        sat_lo_q <= seg_q.sat_lo;
        sat_hi_q <= seg_q.sat_hi;
        y_q      <= y_d;
        sat_q    <= sat_lo_q | sat_hi_q;
      end
    end
  end

  assign y_o   = y_q;
  assign sat_o = sat_q;

endmodule

// File: rtl/pwl_act_simd.sv
// Multi-lane tanh/sigmoid unit: LANES copies of pwl_lane behind one
// ready/valid handshake, plus the saturation event counter.
module pwl_act_simd
  import pwl_act_pkg::*;
#(
  parameter int LANES = 2,
  parameter bit ROUND = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_mode,
  input  logic [W*LANES-1:0] x_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W*LANES-1:0] y_out,
  output logic [15:0]        sat_cnt,
  input  logic               sat_clr
);

  // Handshake: a transfer happens on a side when valid & ready are both high
  // at a rising edge. The whole pipe moves together on adv, so in_ready is
  // combinational from out_ready and a stalled output holds y_out/out_valid.
  logic             adv, accept, out_fire;
  logic             v1_q, v2_q, v3_q;
  logic             mode1_q, mode2_q;
  logic [LANES-1:0] lane_sat;
  logic [3:0]       n_sat;
  logic [16:0]      sat_sum;
  logic [15:0]      sat_cnt_q, sat_cnt_d;

  assign adv       = out_ready | ~v3_q;
  assign in_ready  = adv;
  assign accept    = in_valid & adv;
  assign out_fire  = v3_q & out_ready;
  assign out_valid = v3_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      mode1_q <= 1'b0;
      mode2_q <= 1'b0;
    end else begin
      if (accept) mode1_q <= in_mode;
      if (adv) begin
        v1_q    <= in_valid;
        v2_q    <= v1_q;
        v3_q    <= v2_q;
        mode2_q <= mode1_q;
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    pwl_lane #(.ROUND(ROUND)) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .adv_i     (adv),
      .load_i    (accept),
      .mode_i    (in_mode),
      .mode_s3_i (mode2_q),
      .x_i       (x_in[W*i +: W]),
      .y_o       (y_out[W*i +: W]),
      .sat_o     (lane_sat[i])
    );
  end

  // Clear wins over a same-cycle increment; the count sticks at 0xFFFF.
  always_comb begin
    n_sat = '0;
    for (int i = 0; i < LANES; i++) n_sat = n_sat + 4'(lane_sat[i]);
    sat_sum   = {1'b0, sat_cnt_q} + {13'd0, n_sat};
    sat_cnt_d = sat_cnt_q;
    if (sat_clr)       sat_cnt_d = '0;
    else if (out_fire) sat_cnt_d = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_cnt_q <= '0;
    else        sat_cnt_q <= sat_cnt_d;
  end

  assign sat_cnt = sat_cnt_q;

endmodule

// File: tb/tb_pwl_act_simd.sv
// Directed bench for pwl_act_simd: vector table, back-pressure stream,
// mid-stream reset and saturation counter corners.
module tb_pwl_act_simd;

  localparam int LANES = 2;
  localparam int DW    = 16 * LANES;
  localparam logic [DW-1:0] SATX = {16'sd16384, -16'sd16384};

  logic          clk, rst_n, in_valid, in_mode, out_ready, sat_clr;
  logic [DW-1:0] x_in;
  logic          in_ready, out_valid;
  logic [DW-1:0] y_out;
  logic [15:0]   sat_cnt;
  logic          in_ready_r0, out_valid_r0;
  logic [DW-1:0] y_out_r0;
  logic [15:0]   sat_cnt_r0;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] x0, x1;
    logic        mode;
    logic [15:0] e0, e1;
    logic [15:0] r0_0, r0_1;
    int          nsat;
  } vec_t;

  vec_t          vecs[9];
  logic [DW-1:0] exp_q[$];

  int bp_t[8] = '{-4779, -3413, -2048, -683, 683, 2048, 3413, 4779};
  int m_t[9]  = '{42, 154, 521, 1352, 1975, 1352, 521, 154, 42};
  int c_t[9]  = '{-1912, -1650, -1039, -208, 0, 208, 1039, 1650, 1912};

  pwl_act_simd #(.LANES(LANES), .ROUND(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .x_in(x_in), .out_valid(out_valid), .out_ready(out_ready),
    .y_out(y_out), .sat_cnt(sat_cnt), .sat_clr(sat_clr)
  );

  pwl_act_simd #(.LANES(LANES), .ROUND(1'b0)) dut_r0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_r0),
    .in_mode(in_mode), .x_in(x_in), .out_valid(out_valid_r0), .out_ready(out_ready),
    .y_out(y_out_r0), .sat_cnt(sat_cnt_r0), .sat_clr(sat_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_y(input logic [15:0] x, input logic mode, input bit rnd);
    int xs, k, t;
    xs = int'($signed(x));
    if (mode) xs = xs >>> 1;
    if (xs < -6144)     t = -2038;
    else if (xs >= 6144) t = 2038;
    else begin
      k = 0;
      for (int j = 0; j < 8; j++) if (xs >= bp_t[j]) k = j + 1;
      t = ((m_t[k] * xs + (rnd ? 1024 : 0)) >>> 11) + c_t[k];
      if (t > 32767)  t = 32767;
      if (t < -32768) t = -32768;
    end
    if (mode) t = (t >>> 1) + 1024;
    return t[15:0];
  endfunction

  // One transaction with out_ready high; returns negedges until out_valid.
  task automatic send_one(input logic [DW-1:0] x, input logic mode, output int lat);
    @(posedge clk); #1;
    in_valid = 1'b1; x_in = x; in_mode = mode; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
  endtask

  initial begin
    int lat, exp_sat, sent, got, stale;
    logic stalled, exp_rdy;
    logic [DW-1:0] held_y;

    vecs[0] = '{16'sd0,      16'sd2048,  1'b0, 16'sd0,     16'sd1560, 16'sd0,     16'sd1560, 0};
    vecs[1] = '{-16'sd8192,  16'sd6144,  1'b0, -16'sd2038, 16'sd2038, -16'sd2038, 16'sd2038, 2};
    vecs[2] = '{16'sd0,      16'sd4096,  1'b1, 16'sd1024,  16'sd1804, 16'sd1024,  16'sd1804, 0};
    vecs[3] = '{-16'sd16384, 16'sd16384, 1'b1, 16'sd5,     16'sd2043, 16'sd5,     16'sd2043, 2};
    vecs[4] = '{16'sd1,      -16'sd1,    1'b0, 16'sd1,     -16'sd1,   16'sd0,     -16'sd1,   0};
    vecs[5] = '{-16'sd6144,  16'sd6143,  1'b0, -16'sd2038, 16'sd2038, -16'sd2038, 16'sd2037, 0};
    vecs[6] = '{16'sd683,    16'sd682,   1'b0, 16'sd659,   16'sd658,  16'sd658,   16'sd657,  0};
    vecs[7] = '{-16'sd683,   -16'sd684,  1'b0, -16'sd659,  -16'sd660, -16'sd659,  -16'sd660, 0};
    vecs[8] = '{-16'sd1,     16'sd3,     1'b1, 16'sd1023,  16'sd1024, 16'sd1023,  16'sd1024, 0};

    rst_n = 1'b0; in_valid = 1'b0; in_mode = 1'b0; out_ready = 1'b0;
    sat_clr = 1'b0; x_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_y_out", y_out, 0);
    check("rst_sat_cnt", sat_cnt, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk) rst_n = 1'b1;

    // Table: latency, both rounding variants and the saturation count.
    exp_sat = 0;
    for (int i = 0; i < 9; i++) begin
      send_one({vecs[i].x1, vecs[i].x0}, vecs[i].mode, lat);
      check($sformatf("vec%0d_latency", i), lat, 3);
      check($sformatf("vec%0d_y_round", i), y_out, {vecs[i].e1, vecs[i].e0});
      check($sformatf("vec%0d_y_trunc", i), y_out_r0, {vecs[i].r0_1, vecs[i].r0_0});
      @(posedge clk); #1;
      exp_sat += vecs[i].nsat;
      check($sformatf("vec%0d_sat_cnt", i), sat_cnt, exp_sat);
    end

    // Back-pressure stream against the model, random out_ready and bubbles.
    sent = 0; got = 0; stalled = 1'b0; held_y = '0;
    for (int cyc = 0; cyc < 300 && got < 10; cyc++) begin
      @(negedge clk);
      exp_rdy = out_ready | ~out_valid;
      check("bp_in_ready", in_ready, exp_rdy);
      if (stalled) begin
        check("bp_hold_y", y_out, held_y);
        check("bp_hold_valid", out_valid, 1);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("bp_extra_output", 1, 0);
        else check($sformatf("bp_out%0d", got), y_out, exp_q.pop_front());
        got++;
      end
      stalled = out_valid & ~out_ready;
      held_y  = y_out;
      if (in_valid && in_ready) begin
        exp_q.push_back({ref_y(x_in[31:16], in_mode, 1'b1), ref_y(x_in[15:0], in_mode, 1'b1)});
        sent++;
      end
      @(posedge clk); #1;
      out_ready = 1'($urandom_range(0, 1));
      if (sent < 10) begin
        in_valid = ($urandom_range(0, 3) != 0);
        x_in     = {16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535))};
        in_mode  = 1'($urandom_range(0, 1));
      end else begin
        in_valid = 1'b0;
      end
    end
    check("bp_delivered", got, 10);
    check("bp_queue_empty", exp_q.size(), 0);

    // Reset with three transactions in flight.
    @(posedge clk); #1;
    out_ready = 1'b1; in_mode = 1'b0; in_valid = 1'b1; x_in = SATX;
    @(posedge clk); #1;
    x_in = {16'sd2048, 16'sd6144};
    @(posedge clk); #1;
    x_in = {16'sd6144, -16'sd8192};
    @(posedge clk); #1;
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_y_out", y_out, 0);
    check("mid_rst_sat_cnt", sat_cnt, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("no_stale_output", stale, 0);

    // 32767 saturating transactions: one short of the clamp.
    @(posedge clk); #1;
    in_valid = 1'b1; x_in = SATX; in_mode = 1'b0; out_ready = 1'b1;
    repeat (32767) @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("cnt_65534", sat_cnt, 16'hFFFE);
    send_one(SATX, 1'b0, lat);
    @(posedge clk); #1;
    check("cnt_clamp", sat_cnt, 16'hFFFF);
    send_one(SATX, 1'b0, lat);
    @(posedge clk); #1;
    check("cnt_hold", sat_cnt, 16'hFFFF);

    // Clear coinciding with a saturated output handshake.
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; x_in = SATX; in_mode = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (lat < 20 && !out_valid) begin
      @(negedge clk);
      lat++;
    end
    check("clr_stage_valid", out_valid, 1);
    check("clr_stage_y", y_out, {16'sd2038, -16'sd2038});
    @(posedge clk); #1;
    out_ready = 1'b1; sat_clr = 1'b1;
    @(posedge clk); #1;
    sat_clr = 1'b0;
    check("clr_wins", sat_cnt, 0);
    check("clr_delivered", out_valid, 0);
    send_one(SATX, 1'b0, lat);
    @(posedge clk); #1;
    check("cnt_after_clr", sat_cnt, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
